// File: rtl/div8s4_seq.sv
// div8s4_seq: sequential signed divider, DW-bit dividend by VW-bit divisor.
// Restoring radix-2 division on magnitudes, one quotient bit per clock,
// with a sign fix applied when the last quotient bit is produced.
// valid/ready handshake on both the operand and the result side.
module div8s4_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz,
  output logic          ovf,
  output logic          q_fits_vw
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Smallest quotient magnitude that no longer fits a positive VW-bit signed value.
  localparam logic [DW-1:0] QLIM = DW'(1) << (VW - 1);

  logic [1:0]    state;
  logic [DW-1:0] dvd;      // dividend magnitude shifting out MSB-first, quotient bits shifting in
  logic [VW-1:0] dvs;      // divisor magnitude; 2^(VW-1) still fits unsigned
  logic [VW-1:0] rem;      // partial remainder, always below dvs
  logic          neg_q;
  logic          neg_r;
  logic [CW-1:0] cnt;

  logic [VW:0]   shifted;
  logic          ge;
  logic [VW-1:0] rem_nxt;
  logic [DW-1:0] q_nxt;
  logic          ovf_nxt;
  logic          fits_nxt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    shifted = {rem, dvd[DW-1]};
    ge      = (shifted >= {1'b0, dvs});
    rem_nxt = shifted[VW-1:0];
    if (ge) rem_nxt = VW'(shifted - {1'b0, dvs});
    q_nxt    = {dvd[DW-2:0], ge};
    // Only -2^(DW-1) / -1 yields a positive magnitude with the top bit set.
    ovf_nxt  = !neg_q && q_nxt[DW-1];
    fits_nxt = !ovf_nxt && (neg_q ? (q_nxt <= QLIM) : (q_nxt < QLIM));
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      q_fits_vw <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dvd   <= dividend[DW-1] ? -dividend : dividend;
            dvs   <= divisor[VW-1] ? -divisor : divisor;
            rem   <= '0;
            neg_q <= dividend[DW-1] ^ divisor[VW-1];
            neg_r <= dividend[DW-1];
            cnt   <= CW'(DW);
            if (divisor == '0) begin
              // Divide by zero skips the iterations entirely.
              quotient  <= '0;
              remainder <= '0;
              dz        <= 1'b1;
              ovf       <= 1'b0;
              q_fits_vw <= 1'b0;
              state     <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd <= q_nxt;
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quotient  <= neg_q ? -q_nxt : q_nxt;
            remainder <= neg_r ? -rem_nxt : rem_nxt;
            dz        <= 1'b0;
            ovf       <= ovf_nxt;
            q_fits_vw <= fits_nxt;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div8s4_seq.sv
// Directed self-checking bench for div8s4_seq (DW=8, VW=4).
// Latency is counted in clocks after the accepting edge until out_valid is seen.
module tb_div8s4_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dz;
  logic       ovf;
  logic       q_fits_vw;

  int checks = 0;
  int failures = 0;

  div8s4_seq #(.DW(8), .VW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovf       (ovf),
    .q_fits_vw (q_fits_vw)
  );

  always #5 clk = ~clk;

  // {quotient, remainder, dz, ovf, q_fits_vw, latency}
  function automatic logic [22:0] pack(logic [7:0] q, logic [3:0] r, logic d, logic o,
                                       logic f, logic [7:0] l);
    return {q, r, d, o, f, l};
  endfunction

  // Present one operation, wait for the accept edge, then wait (bounded) for out_valid.
  task automatic do_op(input logic [7:0] dd, input logic [3:0] ds, output logic [7:0] lat);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    dividend = dd;
    divisor  = ds;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 8'd0;
    while (!out_valid && lat < 8'd40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, dz, ovf, q_fits_vw, out_valid, in_ready} !== 19'h00001) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h",
               {quotient, remainder, dz, ovf, q_fits_vw, out_valid, in_ready}, 19'h00001);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    // dividend, divisor, quotient, remainder, dz, ovf, fits
    logic [7:0] dd [7] = '{8'h2A, 8'h80, 8'hC8, 8'h80, 8'h7F, 8'hC0, 8'h64};
    logic [3:0] ds [7] = '{4'hB,  4'h7,  4'h7,  4'hF,  4'h8,  4'h8,  4'h7};
    logic [7:0] eq [7] = '{8'hF8, 8'hEE, 8'hF8, 8'h80, 8'hF1, 8'h08, 8'h0E};
    logic [3:0] er [7] = '{4'h2,  4'hE,  4'h0,  4'h0,  4'h7,  4'h0,  4'h2};
    logic [6:0] eo = 7'b0001000;   // only -128 / -1 overflows
    logic [6:0] ef = 7'b1010000;   // 42/-5 -> -8 and -56/7 -> -8 fit; 8, 14, -15, -18 do not
    logic [7:0] lat;
    for (int i = 0; i < 7; i++) begin
      do_op(dd[i], ds[i], lat);
      checks++;
      if (pack(quotient, remainder, dz, ovf, q_fits_vw, lat) !==
          pack(eq[i], er[i], 1'b0, eo[6-i], ef[6-i], 8'd8)) begin
        failures++;
        $display("FAIL basic[%0d] %h/%h got=%h exp=%h", i, dd[i], ds[i],
                 pack(quotient, remainder, dz, ovf, q_fits_vw, lat),
                 pack(eq[i], er[i], 1'b0, eo[6-i], ef[6-i], 8'd8));
      end
      release_out();
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] lat;
    do_op(8'h25, 4'h0, lat);
    checks++;
    if (pack(quotient, remainder, dz, ovf, q_fits_vw, lat) !== pack(8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0)) begin
      failures++;
      $display("FAIL div_zero got=%h exp=%h", pack(quotient, remainder, dz, ovf, q_fits_vw, lat),
               pack(8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0));
    end
    release_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL div_zero_release got=%b exp=01", {out_valid, in_ready});
    end
    do_op(8'h25, 4'h3, lat);
    checks++;
    if (pack(quotient, remainder, dz, ovf, q_fits_vw, lat) !== pack(8'h0C, 4'h1, 1'b0, 1'b0, 1'b0, 8'd8)) begin
      failures++;
      $display("FAIL after_zero got=%h exp=%h", pack(quotient, remainder, dz, ovf, q_fits_vw, lat),
               pack(8'h0C, 4'h1, 1'b0, 1'b0, 1'b0, 8'd8));
    end
    release_out();
  endtask

  task automatic test_back_pressure();
    logic [7:0] lat;
    do_op(8'h64, 4'h7, lat);   // 100 / 7 = 14 r 2
    checks++;
    if (pack(quotient, remainder, dz, ovf, q_fits_vw, lat) !== pack(8'h0E, 4'h2, 1'b0, 1'b0, 1'b0, 8'd8)) begin
      failures++;
      $display("FAIL hold_first got=%h exp=%h", pack(quotient, remainder, dz, ovf, q_fits_vw, lat),
               pack(8'h0E, 4'h2, 1'b0, 1'b0, 1'b0, 8'd8));
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      dividend = 8'($urandom);
      divisor  = 4'($urandom_range(1, 15));
      @(posedge clk); #1;
      checks++;
      if ({quotient, remainder, dz, ovf, q_fits_vw, out_valid, in_ready} !==
          {8'h0E, 4'h2, 3'b000, 2'b10}) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%h exp=%h", c,
                 {quotient, remainder, dz, ovf, q_fits_vw, out_valid, in_ready},
                 {8'h0E, 4'h2, 3'b000, 2'b10});
      end
    end
    dividend = 8'hEC;          // -20 / 3 = -6 r -2, held on the bus through release
    divisor  = 4'h3;
    release_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL hold_release got=%b exp=01", {out_valid, in_ready});
    end
    do_op(8'hEC, 4'h3, lat);
    checks++;
    if (pack(quotient, remainder, dz, ovf, q_fits_vw, lat) !== pack(8'hFA, 4'hE, 1'b0, 1'b0, 1'b1, 8'd8)) begin
      failures++;
      $display("FAIL hold_next_op got=%h exp=%h", pack(quotient, remainder, dz, ovf, q_fits_vw, lat),
               pack(8'hFA, 4'hE, 1'b0, 1'b0, 1'b1, 8'd8));
    end
    release_out();
  endtask

  task automatic test_reset_mid_calc();
    dividend = 8'h2A;
    divisor  = 4'hB;
    in_valid = 1'b1;
    @(posedge clk); #1;        // accepted; first CALC cycle
    in_valid = 1'b0;
    repeat (2) @(posedge clk); // third CALC cycle
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, dz, ovf, q_fits_vw, out_valid, in_ready} !== 19'h00001) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=%h",
               {quotient, remainder, dz, ovf, q_fits_vw, out_valid, in_ready}, 19'h00001);
    end
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL mid_reset_discard got=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_sweep();
    logic [7:0] lat;
    for (int a = -8; a <= 7; a++) begin
      for (int b = -8; b <= 7; b++) begin
        if (b != 0) begin
          do_op(8'(a * b), 4'(b), lat);
          checks++;
          if (pack(quotient, remainder, dz, ovf, q_fits_vw, lat) !==
              pack(8'(a), 4'h0, 1'b0, 1'b0, 1'b1, 8'd8)) begin
            failures++;
            $display("FAIL sweep %0d*%0d/%0d got=%h exp=%h", a, b, b,
                     pack(quotient, remainder, dz, ovf, q_fits_vw, lat),
                     pack(8'(a), 4'h0, 1'b0, 1'b0, 1'b1, 8'd8));
          end
          release_out();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_pressure();
    test_reset_mid_calc();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
